// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle CPU control unit: opcode/func
// constants, state encoding, control-bundle bit positions and decode helpers.
package multicycle_control_fsm_pkg;

   // Width of the control bundle driven into the datapath.
   localparam int CTRL_W = 15;

   // Opcode field values (instruction[15:12]).
   localparam logic [3:0] OP_BNE   = 4'd0;
   localparam logic [3:0] OP_BEQ   = 4'd1;
   localparam logic [3:0] OP_BGZ   = 4'd2;
   localparam logic [3:0] OP_BLZ   = 4'd3;
   localparam logic [3:0] OP_ADI   = 4'd4;
   localparam logic [3:0] OP_ORI   = 4'd5;
   localparam logic [3:0] OP_LHI   = 4'd6;
   localparam logic [3:0] OP_LWD   = 4'd7;
   localparam logic [3:0] OP_SWD   = 4'd8;
   localparam logic [3:0] OP_JMP   = 4'd9;
   localparam logic [3:0] OP_JAL   = 4'd10;
   localparam logic [3:0] OP_RTYPE = 4'd15;

   // Function field values (instruction[5:0]) for R-type instructions.
   localparam logic [5:0] FN_ALU_MAX = 6'd7;
   localparam logic [5:0] FN_JPR     = 6'd25;
   localparam logic [5:0] FN_JRL     = 6'd26;
   localparam logic [5:0] FN_WWD     = 6'd28;
   localparam logic [5:0] FN_HLT     = 6'd29;

   // Per-instruction state machine encoding.
   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_t;

   // Bit positions inside the control bundle.
   localparam int B_PCSRC_HI    = 14;
   localparam int B_PCSRC_LO    = 13;
   localparam int B_ALUOP       = 12;
   localparam int B_ALUSRCB_HI  = 11;
   localparam int B_ALUSRCB_LO  = 10;
   localparam int B_ALUSRCA     = 9;
   localparam int B_REGWRITE    = 8;
   localparam int B_REGDST      = 7;
   localparam int B_PCWRITECOND = 6;
   localparam int B_PCWRITE     = 5;
   localparam int B_IORD        = 4;
   localparam int B_MEMREAD     = 3;
   localparam int B_MEMWRITE    = 2;
   localparam int B_MEMTOREG    = 1;
   localparam int B_IRWRITE     = 0;

   // Instruction classes that share one control sequence.
   typedef enum logic [3:0] {
      CL_NOP     = 4'd0,
      CL_RALU    = 4'd1,
      CL_ADI     = 4'd2,
      CL_ORI_LHI = 4'd3,
      CL_LWD     = 4'd4,
      CL_SWD     = 4'd5,
      CL_BRANCH  = 4'd6,
      CL_JMP     = 4'd7,
      CL_JAL     = 4'd8,
      CL_JPR     = 4'd9,
      CL_JRL     = 4'd10,
      CL_WWD     = 4'd11,
      CL_HLT     = 4'd12
   } iclass_t;

   // Map opcode/func to an instruction class; anything undefined runs as a NOP.
   function automatic iclass_t classify(input logic [3:0] op, input logic [5:0] fn);
      iclass_t c;
      case (op)
         OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: c = CL_BRANCH;
         OP_ADI:                         c = CL_ADI;
         OP_ORI, OP_LHI:                 c = CL_ORI_LHI;
         OP_LWD:                         c = CL_LWD;
         OP_SWD:                         c = CL_SWD;
         OP_JMP:                         c = CL_JMP;
         OP_JAL:                         c = CL_JAL;
         OP_RTYPE: begin
            if (fn <= FN_ALU_MAX) begin
               c = CL_RALU;
            end else begin
               case (fn)
                  FN_JPR:  c = CL_JPR;
                  FN_JRL:  c = CL_JRL;
                  FN_WWD:  c = CL_WWD;
                  FN_HLT:  c = CL_HLT;
                  default: c = CL_NOP;
               endcase
            end
         end
         default: c = CL_NOP;
      endcase
      return c;
   endfunction

   // ALU operand/operation controls set up in EX; MEM and WB re-issue them
   // so the combinational ALU result stays stable while it is consumed.
   function automatic logic [CTRL_W-1:0] ex_alu_bits(input iclass_t c);
      logic [CTRL_W-1:0] b;
      b = {CTRL_W{1'b0}};
      case (c)
         CL_RALU: begin
            b[B_ALUSRCA] = 1'b1;
            b[B_ALUOP]   = 1'b1;
         end
         CL_ADI: begin
            b[B_ALUSRCA] = 1'b1;
            b[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd2;
            b[B_ALUOP]   = 1'b1;
         end
         CL_ORI_LHI: begin
            b[B_ALUSRCA] = 1'b1;
            b[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd3;
            b[B_ALUOP]   = 1'b1;
         end
         CL_LWD, CL_SWD: begin
            b[B_ALUSRCA] = 1'b1;
            b[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd2;
         end
         CL_BRANCH: begin
            b[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd2;
         end
         CL_WWD: begin
            b[B_ALUSRCA] = 1'b1;
         end
         CL_JPR: begin
            b[B_ALUSRCA] = 1'b1;
            b[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd1;
         end
         default: b = {CTRL_W{1'b0}};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_control_decode.sv
// Combinational decode: (state, opcode, func) -> control bundle, link/WWD
// strobes, next state and the retire flag for the instruction counter.
module control_decode
   import multicycle_control_fsm_pkg::*;
(
   input  state_t            state,
   input  logic [3:0]        opcode,
   input  logic [5:0]        func,
   output logic [CTRL_W-1:0] signal,
   output logic              link_sel,
   output logic              wwd_strobe,
   output state_t            next_state,
   output logic              retire
);

   iclass_t cls_s;

   // Decode the current state and instruction class into controls and transitions.
   always_comb begin
      cls_s      = classify(opcode, func);
      signal     = {CTRL_W{1'b0}};
      link_sel   = 1'b0;
      wwd_strobe = 1'b0;
      next_state = ST_IF;
      retire     = 1'b0;
      case (state)
         ST_IF: begin
            signal[B_IORD]    = 1'b1;
            signal[B_MEMREAD] = 1'b1;
            signal[B_IRWRITE] = 1'b1;
            next_state        = ST_ID;
         end
         ST_ID: begin
            if (cls_s == CL_JMP) begin
               signal[B_PCSRC_HI:B_PCSRC_LO] = 2'd2;
               signal[B_PCWRITE]             = 1'b1;
               retire                        = 1'b1;
               next_state                    = ST_IF;
            end else begin
               // PC <= PC + 1 using the ALU
               signal[B_ALUSRCB_HI:B_ALUSRCB_LO] = 2'd1;
               signal[B_PCWRITE]                 = 1'b1;
               if (cls_s == CL_HLT) begin
                  retire     = 1'b1;
                  next_state = ST_HALT;
               end else if (cls_s == CL_NOP) begin
                  retire     = 1'b1;
                  next_state = ST_IF;
               end else begin
                  retire     = 1'b0;
                  next_state = ST_EX;
               end
            end
         end
         ST_EX: begin
            signal = ex_alu_bits(cls_s);
            case (cls_s)
               CL_RALU, CL_ADI, CL_ORI_LHI: next_state = ST_WB;
               CL_LWD, CL_SWD:              next_state = ST_MEM;
               CL_BRANCH: begin
                  signal[B_PCWRITECOND] = 1'b1;
                  retire                = 1'b1;
                  next_state            = ST_IF;
               end
               CL_WWD: begin
                  wwd_strobe = 1'b1;
                  retire     = 1'b1;
                  next_state = ST_IF;
               end
               CL_JPR: begin
                  signal[B_PCWRITE] = 1'b1;
                  retire            = 1'b1;
                  next_state        = ST_IF;
               end
               CL_JAL, CL_JRL: begin
                  // link register written with the already-incremented PC
                  signal[B_REGWRITE] = 1'b1;
                  link_sel           = 1'b1;
                  next_state         = ST_WB;
               end
               default: next_state = ST_IF;
            endcase
         end
         ST_MEM: begin
            signal = ex_alu_bits(cls_s);
            case (cls_s)
               CL_LWD: begin
                  signal[B_MEMREAD] = 1'b1;
                  next_state        = ST_WB;
               end
               CL_SWD: begin
                  signal[B_MEMWRITE] = 1'b1;
                  retire             = 1'b1;
                  next_state         = ST_IF;
               end
               default: next_state = ST_IF;
            endcase
         end
         ST_WB: begin
            retire     = 1'b1;
            next_state = ST_IF;
            case (cls_s)
               CL_RALU: begin
                  signal             = ex_alu_bits(cls_s);
                  signal[B_REGWRITE] = 1'b1;
                  signal[B_REGDST]   = 1'b1;
               end
               CL_ADI, CL_ORI_LHI: begin
                  signal             = ex_alu_bits(cls_s);
                  signal[B_REGWRITE] = 1'b1;
               end
               CL_LWD: begin
                  signal[B_REGWRITE] = 1'b1;
                  signal[B_MEMTOREG] = 1'b1;
               end
               CL_JAL: begin
                  signal[B_PCSRC_HI:B_PCSRC_LO] = 2'd2;
                  signal[B_PCWRITE]             = 1'b1;
               end
               CL_JRL: begin
                  signal[B_ALUSRCA] = 1'b1;
                  signal[B_PCWRITE] = 1'b1;
               end
               default: retire = 1'b0;
            endcase
         end
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_IF;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle CPU control unit: holds the instruction state and the retired
// instruction counter; all control outputs are decoded from the current state.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
#(
   parameter int WORD_SIZE = 16,
   parameter int SIG_W     = CTRL_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [3:0]           opcode,
   input  logic [5:0]           func,
   output logic [SIG_W-1:0]     signal,
   output logic                 link_sel,
   output logic                 wwd_strobe,
   output logic                 is_halted,
   output logic [WORD_SIZE-1:0] num_inst
);

   state_t               state_q;
   state_t               state_d;
   logic [WORD_SIZE-1:0] num_inst_q;
   logic [WORD_SIZE-1:0] num_inst_d;
   logic [CTRL_W-1:0]    signal_s;
   logic                 link_sel_s;
   logic                 wwd_strobe_s;
   logic                 retire_s;

   control_decode u_decode (
      .state      (state_q),
      .opcode     (opcode),
      .func       (func),
      .signal     (signal_s),
      .link_sel   (link_sel_s),
      .wwd_strobe (wwd_strobe_s),
      .next_state (state_d),
      .retire     (retire_s)
   );

   // Count an instruction on the edge leaving its final state; wraps naturally.
   always_comb begin
      num_inst_d = num_inst_q + {{(WORD_SIZE-1){1'b0}}, retire_s};
   end

   // State and retired-instruction registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IF;
         num_inst_q <= {WORD_SIZE{1'b0}};
      end else begin
         state_q    <= state_d;
         num_inst_q <= num_inst_d;
      end
   end

   // Force every output low while reset is held so no write escapes mid-abort.
   always_comb begin
      if (reset) begin
         signal     = {SIG_W{1'b0}};
         link_sel   = 1'b0;
         wwd_strobe = 1'b0;
         is_halted  = 1'b0;
         num_inst   = {WORD_SIZE{1'b0}};
      end else begin
         signal     = signal_s;
         link_sel   = link_sel_s;
         wwd_strobe = wwd_strobe_s;
         is_halted  = (state_q == ST_HALT);
         num_inst   = num_inst_q;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction expected
// control sequences come from a table-style model, compared every cycle.
module tb_multicycle_control_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  opcode;
   logic [5:0]  func;
   logic [14:0] signal;
   logic        link_sel;
   logic        wwd_strobe;
   logic        is_halted;
   logic [15:0] num_inst;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.WORD_SIZE(16), .SIG_W(15)) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .func       (func),
      .signal     (signal),
      .link_sel   (link_sel),
      .wwd_strobe (wwd_strobe),
      .is_halted  (is_halted),
      .num_inst   (num_inst)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic        chk_en   = 1'b0;
   logic [14:0] exp_sig  = 15'd0;
   logic        exp_lnk  = 1'b0;
   logic        exp_wwd  = 1'b0;
   logic        exp_halt = 1'b0;
   logic [15:0] exp_num  = 16'd0;
   logic [15:0] model_cnt;

   // expected per-cycle outputs of the instruction being executed
   logic [14:0] m_sig [8];
   logic        m_lnk [8];
   logic        m_wwd [8];
   int          m_len;
   bit          m_halt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // compare every output against the model on each falling edge
   always @(negedge clk) begin
      if (chk_en) begin
         chk("signal",     {17'd0, signal},     {17'd0, exp_sig});
         chk("link_sel",   {31'd0, link_sel},   {31'd0, exp_lnk});
         chk("wwd_strobe", {31'd0, wwd_strobe}, {31'd0, exp_wwd});
         chk("is_halted",  {31'd0, is_halted},  {31'd0, exp_halt});
         chk("num_inst",   {16'd0, num_inst},   {16'd0, exp_num});
      end
   end

   task automatic push(input logic [14:0] s, input logic l, input logic w);
      m_sig[m_len] = s;
      m_lnk[m_len] = l;
      m_wwd[m_len] = w;
      m_len++;
   endtask

   // Expected cycle-by-cycle controls for one instruction, written directly
   // from the per-class control tables.
   task automatic expand(input logic [3:0] op, input logic [5:0] fn);
      bit rt;
      rt     = (op == 4'd15);
      m_len  = 0;
      m_halt = 1'b0;
      push(15'h0019, 1'b0, 1'b0);                       // IF
      if (op == 4'd9) begin
         push(15'h4020, 1'b0, 1'b0);                    // JMP
      end else begin
         push(15'h0420, 1'b0, 1'b0);                    // ID: PC+1
         if (rt && fn <= 6'd7) begin
            push(15'h1200, 1'b0, 1'b0); push(15'h1380, 1'b0, 1'b0);
         end else if (op == 4'd4) begin
            push(15'h1A00, 1'b0, 1'b0); push(15'h1B00, 1'b0, 1'b0);
         end else if (op == 4'd5 || op == 4'd6) begin
            push(15'h1E00, 1'b0, 1'b0); push(15'h1F00, 1'b0, 1'b0);
         end else if (op == 4'd7) begin
            push(15'h0A00, 1'b0, 1'b0); push(15'h0A08, 1'b0, 1'b0); push(15'h0102, 1'b0, 1'b0);
         end else if (op == 4'd8) begin
            push(15'h0A00, 1'b0, 1'b0); push(15'h0A04, 1'b0, 1'b0);
         end else if (op <= 4'd3) begin
            push(15'h0840, 1'b0, 1'b0);
         end else if (op == 4'd10) begin
            push(15'h0100, 1'b1, 1'b0); push(15'h4020, 1'b0, 1'b0);
         end else if (rt && fn == 6'd25) begin
            push(15'h0620, 1'b0, 1'b0);
         end else if (rt && fn == 6'd26) begin
            push(15'h0100, 1'b1, 1'b0); push(15'h0220, 1'b0, 1'b0);
         end else if (rt && fn == 6'd28) begin
            push(15'h0200, 1'b0, 1'b1);
         end else if (rt && fn == 6'd29) begin
            m_halt = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         reset    = 1'b1;
         chk_en   = 1'b1;
         exp_sig  = 15'd0;
         exp_lnk  = 1'b0;
         exp_wwd  = 1'b0;
         exp_halt = 1'b0;
         exp_num  = 16'd0;
      end
      model_cnt = 16'd0;
   endtask

   // Run one instruction; abort_at stops before that cycle (reset follows),
   // wrap preloads the counter to 0xFFFF, lit_* pin a literal at cycle lit_c.
   task automatic run_instr(input logic [3:0] op, input logic [5:0] fn, input int abort_at,
                            input bit wrap, input int lit_c, input logic [14:0] lit_sig,
                            input int lit_num);
      expand(op, fn);
      for (int c = 0; c < m_len && c != abort_at; c++) begin
         step();
         reset  = 1'b0;
         opcode = op;
         func   = fn;
         if (wrap && c == 0) force dut.num_inst_d = 16'hFFFF;
         if (wrap && c == 1) begin
            release dut.num_inst_d;
            model_cnt = 16'hFFFF;
         end
         exp_sig  = m_sig[c];
         exp_lnk  = m_lnk[c];
         exp_wwd  = m_wwd[c];
         exp_halt = 1'b0;
         exp_num  = model_cnt;
         if (c == lit_c) begin
            @(negedge clk);
            chk("lit_signal", {17'd0, signal}, {17'd0, lit_sig});
            if (lit_num >= 0) chk("lit_num_inst", {16'd0, num_inst}, lit_num);
         end
      end
      if (abort_at < 0 || abort_at >= m_len) model_cnt = model_cnt + 16'd1;
   endtask

   task automatic halt_idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         reset    = 1'b0;
         opcode   = 4'($urandom_range(0, 15));
         func     = 6'($urandom_range(0, 63));
         exp_sig  = 15'd0;
         exp_lnk  = 1'b0;
         exp_wwd  = 1'b0;
         exp_halt = 1'b1;
         exp_num  = model_cnt;
      end
   endtask

   // time bound for the whole run
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   // directed scenarios followed by randomized instruction streams
   initial begin
      reset     = 1'b1;
      opcode    = 4'd0;
      func      = 6'd0;
      model_cnt = 16'd0;
      do_reset(3);
      run_instr(4'd15, 6'd0, -1, 1'b0, 3, 15'h1380, -1);      // ADD, WB pinned
      run_instr(4'd15, 6'd0, 2, 1'b0, -1, 15'd0, -1);         // ADD aborted in EX
      do_reset(3);
      run_instr(4'd15, 6'd1, -1, 1'b0, 0, 15'h0019, 0);       // first IF after reset
      run_instr(4'd7, 6'd0, -1, 1'b0, 3, 15'h0A08, 1);        // LWD MEM
      run_instr(4'd7, 6'd0, -1, 1'b0, 4, 15'h0102, 2);        // LWD WB
      do_reset(1);
      run_instr(4'd0, 6'd0, -1, 1'b0, 2, 15'h0840, 0);        // BNE EX
      run_instr(4'd9, 6'd0, -1, 1'b0, 1, 15'h4020, 1);        // JMP ID
      run_instr(4'd15, 6'd28, -1, 1'b0, 0, 15'h0019, 2);      // WWD after 2 retires
      run_instr(4'd15, 6'd29, -1, 1'b0, -1, 15'd0, -1);       // HLT
      halt_idle(20);
      do_reset(2);
      run_instr(4'd11, 6'd0, -1, 1'b1, 1, 15'h0420, 16'hFFFF); // NOP wraps counter
      run_instr(4'd10, 6'd0, -1, 1'b0, 0, 15'h0019, 0);       // JAL sees 0x0000
      run_instr(4'd15, 6'd26, -1, 1'b0, 2, 15'h0100, 1);      // JRL EX
      for (int k = 0; k < 80; k++) begin
         logic [3:0] op;
         logic [5:0] fn;
         int         sel;
         int         ab;
         op  = 4'($urandom_range(0, 15));
         sel = int'($urandom_range(0, 11));
         case (sel)
            8:       fn = 6'd25;
            9:       fn = 6'd26;
            10:      fn = 6'd28;
            11:      fn = 6'($urandom_range(0, 63));
            default: fn = 6'(sel);
         endcase
         if ($urandom_range(0, 19) == 0) fn = 6'd29;
         ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : -1;
         run_instr(op, fn, ab, 1'b0, -1, 15'd0, -1);
         if (ab >= 0 && ab < m_len) begin
            do_reset(1 + int'($urandom_range(0, 2)));
         end else if (m_halt) begin
            halt_idle(1 + int'($urandom_range(0, 3)));
            do_reset(1);
         end
      end
      step();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
